// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: request/response bundle between three requesters, the arbiter and a single-port RAM.
// Ports (all logic):
//   d_*   data port: req_valid/ready/we/addr[29:0]/wdata[31:0]/be[3:0], rsp_valid/rdata[31:0]
//   f_*   fetch port: req_valid/ready/addr[29:0], kill, rsp_valid/rdata[31:0]
//   x_*   external port: req_valid/ready/lock/we/addr/wdata/be, rsp_valid/rdata
//   mem_* RAM command en/we/addr/wdata/be and read data mem_rdata
// Modports: slave is the arbiter's view; master is the environment's view (requesters plus RAM).
interface ram_port_arbiter_if;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [29:0] d_req_addr;
  logic [31:0] d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_be;
  logic        f_req_valid, f_req_ready, f_kill, f_rsp_valid;
  logic [29:0] f_req_addr;
  logic [31:0] f_rsp_rdata;
  logic        x_req_valid, x_req_ready, x_req_lock, x_req_we, x_rsp_valid;
  logic [29:0] x_req_addr;
  logic [31:0] x_req_wdata, x_rsp_rdata;
  logic [3:0]  x_req_be;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  modport slave (
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    output d_req_ready, d_rsp_valid, d_rsp_rdata,
    input  f_req_valid, f_req_addr, f_kill,
    output f_req_ready, f_rsp_valid, f_rsp_rdata,
    input  x_req_valid, x_req_lock, x_req_we, x_req_addr, x_req_wdata, x_req_be,
    output x_req_ready, x_rsp_valid, x_rsp_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );
  modport master (
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_be,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata,
    output f_req_valid, f_req_addr, f_kill,
    input  f_req_ready, f_rsp_valid, f_rsp_rdata,
    output x_req_valid, x_req_lock, x_req_we, x_req_addr, x_req_wdata, x_req_be,
    input  x_req_ready, x_rsp_valid, x_rsp_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port sync RAM between data, fetch and external (x) requesters.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ram_port_arbiter_if.slave: requester handshakes, responses and the RAM command/read data
// Priority x > d > f, with f promoted above d after STARVE_LIMIT consecutive denials.
// One access per cycle; read data returns one cycle after the grant to the port that owned the read.
module ram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic rst_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic {ARB, XLOCK} state_t;
  typedef enum logic [1:0] {OWN_D, OWN_F, OWN_X} owner_t;
  state_t state;
  owner_t owner;
  logic [CNT_W-1:0] wait_cnt;
  logic pend, kill, locked, promote, gx, gd, gf;
  // The lock holds only while x keeps x_req_lock high; the release cycle already arbitrates normally.
  assign locked = (state == XLOCK) && bus.x_req_lock;
  assign promote = wait_cnt >= CNT_W'(STARVE_LIMIT);
  // Grants are gated by rst_n so every command/handshake output is quiet while reset is held.
  assign gx = rst_n && bus.x_req_valid;
  assign gf = rst_n && !locked && !bus.x_req_valid && bus.f_req_valid && (promote || !bus.d_req_valid);
  assign gd = rst_n && !locked && !bus.x_req_valid && bus.d_req_valid && !gf;
  assign bus.x_req_ready = gx;
  assign bus.d_req_ready = gd;
  assign bus.f_req_ready = gf;
  assign bus.mem_en = gx || gd || gf;
  assign bus.mem_we = gx ? bus.x_req_we : gd && bus.d_req_we;
  assign bus.mem_addr = gx ? bus.x_req_addr : gd ? bus.d_req_addr : gf ? bus.f_req_addr : '0;
  assign bus.mem_wdata = gx ? bus.x_req_wdata : gd ? bus.d_req_wdata : '0;
  assign bus.mem_be = gx ? bus.x_req_be : gd ? bus.d_req_be : '0;
  // A fetch response dies if it was killed at grant time (kill) or is killed in the response cycle.
  assign bus.d_rsp_valid = pend && owner == OWN_D;
  assign bus.f_rsp_valid = pend && owner == OWN_F && !kill && !bus.f_kill;
  assign bus.x_rsp_valid = pend && owner == OWN_X;
  assign bus.d_rsp_rdata = bus.d_rsp_valid ? bus.mem_rdata : '0;
  assign bus.f_rsp_rdata = bus.f_rsp_valid ? bus.mem_rdata : '0;
  assign bus.x_rsp_rdata = bus.x_rsp_valid ? bus.mem_rdata : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      owner <= OWN_D;
      wait_cnt <= '0;
      pend <= 1'b0;
      kill <= 1'b0;
    end else begin
      state <= (locked || (gx && bus.x_req_lock)) ? XLOCK : ARB;
      // promote doubles as the saturation test: once at the limit the count holds.
      wait_cnt <= (bus.f_req_valid && !gf) ? (promote ? wait_cnt : wait_cnt + 1'b1) : '0;
      pend <= bus.mem_en && !bus.mem_we;
      owner <= gx ? OWN_X : gf ? OWN_F : OWN_D;
      kill <= gf && bus.f_kill;
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_ram_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_port_arbiter_if bus();
  ram_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // RAM environment: written by whatever the DUT commands.
  logic [31:0] ram [64];
  // Shadow memory: written by the model's own idea of which writes happen.
  logic [31:0] sh [64];
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) ram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else bus.mem_rdata <= ram[bus.mem_addr[5:0]];
    end
  // Behavioural model: owner of the pending read (0 none, 1 d, 2 f, 3 x), denial count, lock flag.
  int m_wait, p_own, g;
  bit m_lock, p_kill, ev_d, ev_f, ev_x, e_we;
  logic [31:0] p_data, e_wdata;
  logic [29:0] e_addr;
  logic [3:0] e_be;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl", 32'({bus.d_req_ready, bus.f_req_ready, bus.x_req_ready, bus.d_rsp_valid,
          bus.f_rsp_valid, bus.x_rsp_valid, bus.mem_en, bus.mem_we}), 32'd0);
      chk("rst_rdata", bus.d_rsp_rdata | bus.f_rsp_rdata | bus.x_rsp_rdata, 32'd0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      m_wait = 0;
      m_lock = 1'b0;
      p_own = 0;
      p_kill = 1'b0;
    end else begin
      ev_d = p_own == 1;
      ev_f = p_own == 2 && !p_kill && !bus.f_kill;
      ev_x = p_own == 3;
      chk("rsp_valid", 32'({bus.d_rsp_valid, bus.f_rsp_valid, bus.x_rsp_valid}), 32'({ev_d, ev_f, ev_x}));
      chk("d_rsp_rdata", bus.d_rsp_rdata, ev_d ? p_data : 32'd0);
      chk("f_rsp_rdata", bus.f_rsp_rdata, ev_f ? p_data : 32'd0);
      chk("x_rsp_rdata", bus.x_rsp_rdata, ev_x ? p_data : 32'd0);
      if (bus.x_req_valid) g = 3;
      else if (m_lock && bus.x_req_lock) g = 0;
      else if (bus.f_req_valid && (m_wait >= LIMIT || !bus.d_req_valid)) g = 2;
      else if (bus.d_req_valid) g = 1;
      else g = 0;
      chk("ready", 32'({bus.d_req_ready, bus.f_req_ready, bus.x_req_ready}), 32'({g == 1, g == 2, g == 3}));
      e_we = (g == 1 && bus.d_req_we) || (g == 3 && bus.x_req_we);
      e_addr = g == 1 ? bus.d_req_addr : g == 2 ? bus.f_req_addr : bus.x_req_addr;
      e_wdata = g == 1 ? bus.d_req_wdata : bus.x_req_wdata;
      e_be = g == 1 ? bus.d_req_be : bus.x_req_be;
      chk("mem_ctl", 32'({bus.mem_en, bus.mem_we}), 32'({g != 0, e_we}));
      if (g != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      if (e_we) begin
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("mem_be", 32'(bus.mem_be), 32'(e_be));
        for (int b = 0; b < 4; b++)
          if (e_be[b]) sh[e_addr[5:0]][8*b +: 8] = e_wdata[8*b +: 8];
      end
      m_lock = (m_lock && bus.x_req_lock) || (g == 3 && bus.x_req_lock);
      m_wait = (bus.f_req_valid && g != 2) ? (m_wait < LIMIT ? m_wait + 1 : LIMIT) : 0;
      p_own = (g != 0 && !e_we) ? g : 0;
      p_kill = g == 2 && bus.f_kill;
      p_data = sh[e_addr[5:0]];
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_req_addr = '0; bus.d_req_wdata = '0; bus.d_req_be = '0;
    bus.f_req_valid = 1'b0; bus.f_req_addr = '0; bus.f_kill = 1'b0;
    bus.x_req_valid = 1'b0; bus.x_req_lock = 1'b0; bus.x_req_we = 1'b0; bus.x_req_addr = '0;
    bus.x_req_wdata = '0; bus.x_req_be = '0;
  endtask
  logic [9:0] pat;
  logic acc_d, acc_f, acc_x;
  initial begin
    idle();
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      sh[i] = ram[i];
    end
    ram[16] = 32'hDEADBEEF; sh[16] = 32'hDEADBEEF;
    ram[32] = 32'hA5A5A5A5; sh[32] = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // d read of 0x10: ready now, response exactly one cycle later.
    bus.d_req_valid = 1'b1; bus.d_req_addr = 30'h10;
    @(negedge clk) chk("t1_d_ready", 32'(bus.d_req_ready), 32'd1);
    cyc(); idle();
    @(negedge clk) chk("t1_rsp_valid", 32'({bus.d_rsp_valid, bus.f_rsp_valid, bus.x_rsp_valid}), 32'b100);
    chk("t1_rdata", bus.d_rsp_rdata, 32'hDEADBEEF);
    cyc();
    @(negedge clk) chk("t1_rsp_once", 32'({bus.d_rsp_valid, bus.f_rsp_valid, bus.x_rsp_valid}), 32'b000);
    cyc();
    // d and f contend: f wins after exactly four denials.
    bus.d_req_valid = 1'b1; bus.d_req_addr = 30'd1;
    bus.f_req_valid = 1'b1; bus.f_req_addr = 30'd2;
    pat = '0;
    repeat (10) begin
      @(negedge clk) pat = {pat[8:0], bus.f_req_ready};
      cyc();
    end
    chk("t2_pattern", 32'(pat), 32'b0000100001);
    idle(); cyc();
    // x read and d partial write to 0x20 in the same cycle.
    bus.x_req_valid = 1'b1; bus.x_req_addr = 30'h20;
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b1; bus.d_req_addr = 30'h20;
    bus.d_req_wdata = 32'h11223344; bus.d_req_be = 4'b0011;
    @(negedge clk) chk("t3_x_first", 32'({bus.d_req_ready, bus.x_req_ready}), 32'b01);
    cyc(); bus.x_req_valid = 1'b0;
    @(negedge clk) chk("t3_d_be", 32'({bus.d_req_ready, bus.mem_be}), 32'b10011);
    chk("t3_old_value", bus.x_rsp_rdata, 32'hA5A5A5A5);
    cyc(); idle();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 30'h20;
    cyc(); idle();
    @(negedge clk) chk("t3_merged", bus.d_rsp_rdata, 32'hA5A53344);
    cyc();
    // x lock with d (and later f) waiting: both held off, d granted in the release cycle.
    bus.d_req_valid = 1'b1; bus.d_req_addr = 30'd5;
    bus.x_req_valid = 1'b1; bus.x_req_lock = 1'b1; bus.x_req_we = 1'b1; bus.x_req_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.x_req_addr = 30'(i); bus.x_req_wdata = $urandom;
      if (i >= 1) begin bus.f_req_valid = 1'b1; bus.f_req_addr = 30'd6; end
      @(negedge clk) chk("t4_locked", 32'({bus.d_req_ready, bus.f_req_ready, bus.x_req_ready}), 32'b001);
      cyc();
    end
    bus.x_req_valid = 1'b0; bus.x_req_lock = 1'b0;
    @(negedge clk) chk("t4_release", 32'({bus.d_req_ready, bus.f_req_ready}), 32'b10);
    cyc(); idle(); cyc(); cyc();
    // Fetch kill in the response cycle, then an unkilled fetch, then kill at grant time.
    bus.f_req_valid = 1'b1; bus.f_req_addr = 30'h10;
    @(negedge clk) chk("t5_f_ready", 32'(bus.f_req_ready), 32'd1);
    cyc(); bus.f_req_valid = 1'b0; bus.f_kill = 1'b1;
    @(negedge clk) chk("t5_killed", 32'(bus.f_rsp_valid), 32'd0);
    cyc(); bus.f_kill = 1'b0; bus.f_req_valid = 1'b1; bus.f_req_addr = 30'h20;
    cyc(); bus.f_req_valid = 1'b0;
    @(negedge clk) chk("t5_rsp", 32'(bus.f_rsp_valid), 32'd1);
    chk("t5_rdata", bus.f_rsp_rdata, 32'hA5A53344);
    cyc(); bus.f_req_valid = 1'b1; bus.f_req_addr = 30'd1; bus.f_kill = 1'b1;
    cyc(); idle();
    @(negedge clk) chk("t5_grant_kill", 32'(bus.f_rsp_valid), 32'd0);
    cyc();
    // Reset right after a d read grant drops its response.
    bus.d_req_valid = 1'b1; bus.d_req_addr = 30'h10;
    cyc(); rst_n = 1'b0;
    bus.f_req_valid = 1'b1; bus.x_req_valid = 1'b1;
    @(negedge clk) chk("t6_quiet", 32'({bus.d_req_ready, bus.f_req_ready, bus.x_req_ready,
        bus.d_rsp_valid, bus.mem_en}), 32'd0);
    cyc(); idle(); rst_n = 1'b1;
    @(negedge clk) chk("t6_no_rsp", 32'({bus.d_rsp_valid, bus.f_rsp_valid, bus.x_rsp_valid}), 32'd0);
    cyc();
    // Randomized traffic honouring hold-until-ready on each port.
    repeat (3000) begin
      @(negedge clk);
      acc_d = bus.d_req_ready; acc_f = bus.f_req_ready; acc_x = bus.x_req_ready;
      cyc();
      if (!bus.d_req_valid || acc_d) begin
        bus.d_req_valid = 1'($urandom_range(1)); bus.d_req_we = 1'($urandom_range(1));
        bus.d_req_addr = 30'($urandom_range(63)); bus.d_req_wdata = $urandom; bus.d_req_be = 4'($urandom);
      end else if ($urandom_range(7) == 0) bus.d_req_valid = 1'b0;
      if (!bus.f_req_valid || acc_f) begin
        bus.f_req_valid = 1'($urandom_range(1)); bus.f_req_addr = 30'($urandom_range(63));
      end else if ($urandom_range(7) == 0) bus.f_req_valid = 1'b0;
      if (!bus.x_req_valid || acc_x) begin
        bus.x_req_valid = $urandom_range(3) == 0; bus.x_req_lock = $urandom_range(5) == 0;
        bus.x_req_we = 1'($urandom_range(1)); bus.x_req_addr = 30'($urandom_range(63));
        bus.x_req_wdata = $urandom; bus.x_req_be = 4'($urandom);
      end else if ($urandom_range(7) == 0) bus.x_req_valid = 1'b0;
      bus.f_kill = $urandom_range(3) == 0;
    end
    idle();
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
